// File: rtl/demux_1an_hs.sv
// 1:N word demux with one-entry per-lane output registers; lane from sel_in (MODE=0) or round-robin (MODE=1).
// Latency 1 cycle; ready_out is combinational from the target lane's full/ready, illegal selects are dropped.
module demux_1an_hs #(
    parameter int WIDTH  = 8,
    parameter int N_OUT  = 2,
    parameter int MODE   = 0,
    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     valid_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ready_out,
    output logic [N_OUT-1:0]         valid_out,
    output logic [N_OUT*WIDTH-1:0]   data_out,
    input  logic [N_OUT-1:0]         ready_in,
    output logic [SEL_W-1:0]         rr_ptr,
    output logic                     err_sel
);

    localparam logic [SEL_W:0]   N_OUT_W = (SEL_W+1)'(N_OUT);
    localparam logic [SEL_W-1:0] LAST_W  = SEL_W'(N_OUT - 1);

    logic [N_OUT-1:0]            r_full;
    logic [N_OUT-1:0][WIDTH-1:0] r_data;
    logic [SEL_W-1:0]            r_rr_ptr;
    logic                        r_err;

    logic [SEL_W-1:0]            w_tgt;
    logic                        w_sel_ok;
    logic [N_OUT-1:0]            w_tgt_oh;
    logic                        w_stall;
    logic                        w_ready;
    logic                        w_accept;
    logic [N_OUT-1:0]            w_load;

    assign w_tgt    = (MODE != 0) ? r_rr_ptr : sel_in;
    assign w_sel_ok = (MODE != 0) || ({1'b0, sel_in} < N_OUT_W);

    // An out-of-range target decodes to all-zero, so it never stalls and never loads.
    always_comb begin
        w_tgt_oh = '0;
        for (int i = 0; i < N_OUT; i++) begin
            w_tgt_oh[i] = (w_tgt == SEL_W'(i));
        end
    end

    assign w_stall  = |(w_tgt_oh & r_full & ~ready_in);
    assign w_ready  = ~w_stall;
    assign w_accept = valid_in & w_ready;
    assign w_load   = w_accept ? w_tgt_oh : '0;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_full <= '0;
            r_data <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                r_full[i] <= w_load[i] | (r_full[i] & ~ready_in[i]);
                if (w_load[i]) begin
                    r_data[i] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_rr_ptr <= '0;
        end else if ((MODE != 0) && w_accept) begin
            r_rr_ptr <= (r_rr_ptr == LAST_W) ? '0 : r_rr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_err <= 1'b0;
        end else begin
            r_err <= valid_in & ~w_sel_ok;
        end
    end

    assign ready_out = w_ready;
    assign valid_out = r_full;
    assign data_out  = r_data;
    assign rr_ptr    = r_rr_ptr;
    assign err_sel   = r_err;

    a_rr_in_range: assert property (@(posedge clk) disable iff (!reset_L)
        {1'b0, r_rr_ptr} < N_OUT_W);

endmodule
